alu_issue_seq: RTL

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_issue_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states and
// the queued command record.
package alu_seq_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h7;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h8;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h9;
    localparam logic [OP_W-1:0] OP_SEQ  = 4'hA;
    localparam logic [OP_W-1:0] ALU_NOP = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } cmd_t;

    // Only arithmetic ops produce meaningful carry/overflow flags.
    function automatic logic has_flags(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command FIFO; count, full and empty are registered alongside the
// pointers so downstream logic sees clean flop outputs.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  cmd_t             wdata,
    input  logic             pop,
    output cmd_t             rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Sequences queued commands through an external registered ALU:
// IDLE -> ISSUE -> CAPTURE -> HOLD, one result held until res_ready.
module alu_issue_seq
    import alu_seq_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [OPND_W-1:0]   cmd_a,
    input  logic [OPND_W-1:0]   cmd_b,
    output logic [2*OPND_W-1:0] alu_ui,
    output logic [OP_W-1:0]     alu_op,
    input  logic [RES_W-1:0]    alu_result,
    input  logic                alu_carry,
    input  logic                alu_ovf,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RES_W-1:0]    res_data,
    output logic                res_carry,
    output logic                res_ovf,
    output logic [CNT_W-1:0]    occupancy
);

    state_t              state;
    state_t              state_nxt;
    cmd_t                head;
    cmd_t                wcmd;
    logic                full;
    logic                empty;
    logic                pop;
    logic [2*OPND_W-1:0] ui_nxt;
    logic [OP_W-1:0]     op_nxt;
    logic                flag_en;

    assign cmd_ready = ~full;
    assign wcmd      = '{op: cmd_op, a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE:    if (!empty) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                pop       = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD:    if (res_ready) state_nxt = empty ? S_IDLE : S_ISSUE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // ALU drive is registered, so it is loaded on entry into ISSUE.
    always_comb begin
        ui_nxt = '0;
        op_nxt = ALU_NOP;
        if (state_nxt == S_ISSUE) begin
            ui_nxt = {head.a, head.b};
            op_nxt = head.op;
        end
    end

    // Head is still in the FIFO during CAPTURE; it names the op being captured.
    assign flag_en = has_flags(head.op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ui    <= '0;
            alu_op    <= ALU_NOP;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            alu_ui    <= ui_nxt;
            alu_op    <= op_nxt;
            res_valid <= (state_nxt == S_HOLD);
            if (state == S_CAPTURE) begin
                res_data  <= alu_result;
                res_carry <= flag_en & alu_carry;
                res_ovf   <= flag_en & alu_ovf;
            end
        end
    end

endmodule
